avalon_harvard_sequencer: RTL and testbench
===========================================

Name: avalon_harvard_sequencer

Overview:
- Sequences the Harvard MIPS core onto one shared Avalon-MM master port. Arbitrates between the instruction-fetch port and the data port.
- Stalls the core with cpu_clk_enable / cpu_pause while bus transfers complete. Presents registered instruction and data words to the core as if memory were combinational.
- Sits between mips_cpu_harvard and the Avalon interconnect in the avalon_bus top level.

Parameters:
- ADDR_W, 32, Avalon address width; core addresses are truncated or zero-extended to this width.
- WAIT_LIMIT, 255, maximum waitrequest cycles per transfer before timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_active  in  1  core active flag
- cpu_instr_address  in  32  core PC
- cpu_data_address  in  32  core data address
- cpu_data_read  in  1  core load request, combinational from instr_readdata
- cpu_data_write  in  1  core store request
- cpu_data_writedata  in  32  store data
- cpu_instr_readdata  out  32  registered instruction word
- cpu_data_readdata  out  32  registered load word
- cpu_clk_enable  out  1  core advance strobe
- cpu_pause  out  1  suppresses core side effects while the core is stalled
- avm_address  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  32  Avalon write data
- avm_byteenable  out  4  constant 4'hF
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  Avalon stall
- bus_error  out  1  sticky error flag
- halted  out  1  core has finished

Behaviour:
- States: RST, FETCH, EXEC, DRD, DWR, COMMIT, HALT.
- Reset (synchronous, dominates every state):
  - Next state is RST.
  - Register contents: instr_q=0, data_q=0, bus_error=0, wait counter=0.
  - Outputs during the reset cycle: cpu_clk_enable=1, so the core resets in the same cycle. avm_read=0, avm_write=0, cpu_pause=1.
  - An in-flight Avalon transfer is abandoned; the interconnect must tolerate this.
- RST: one cycle, cpu_clk_enable=0, then -> FETCH.
- FETCH:
  - If cpu_active=0 -> HALT; no bus access is issued.
  - Otherwise avm_read=1, avm_address=PC.
  - Hold address and read stable while avm_waitrequest=1.
  - On the first cycle with waitrequest=0: instr_q<=avm_readdata, -> EXEC.
- EXEC: one cycle, no bus activity, so the core decodes instr_q.
  - cpu_data_read=1 -> DRD.
  - Else cpu_data_write=1 -> DWR.
  - Else -> COMMIT.
  - Both read and write asserted: read wins, bus_error<=1.
- DRD: avm_read at the data address. On waitrequest=0: data_q<=avm_readdata, -> COMMIT.
- DWR: avm_write with avm_writedata=cpu_data_writedata. On waitrequest=0 -> COMMIT.
- COMMIT: cpu_clk_enable=1 and cpu_pause=0 for exactly one cycle (PC, register file and HI/LO update), then -> FETCH.
- Outside COMMIT and reset: cpu_clk_enable=0, cpu_pause=1.
- HALT: halted=1, bus idle, remains until reset.
- avm_read and avm_write are never both 1.
- Latency with zero wait states:
  - ALU, branch or jump instruction: 3 cycles (FETCH, EXEC, COMMIT).
  - Load or store: 4 cycles.
  - Each waitrequest cycle adds 1.
- Timeout, when WAIT_LIMIT>0:
  - An 8-bit+ wait counter increments per waitrequest cycle and clears on state change.
  - Reaching WAIT_LIMIT sets bus_error<=1, drops the request, and -> HALT.
- cpu_data_readdata and cpu_instr_readdata hold their values across COMMIT. The core samples data_readdata at the COMMIT edge.

Optional Feature:
- Macro: AVALON_SEQ_PERF_COUNT_EN.
- Defined: adds ports perf_instr_count out 32 and perf_stall_count out 32.
  - perf_instr_count increments in each COMMIT cycle.
  - perf_stall_count increments in each non-COMMIT, non-HALT, non-RST cycle.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package avalon_seq_pkg holds:
  - seq_state_t enum (RST, FETCH, EXEC, DRD, DWR, COMMIT, HALT);
  - BYTEENABLE_ALL=4'hF;
  - the word-align function.
- One sub-module, avalon_wait_timer: wait counter plus limit compare, with clear and inc inputs and an expired output.

Test Plan:
- Reset, then fetch at PC 0xBFC00000, zero waits, addiu: avm_read seen with address 0xBFC00000; cpu_clk_enable pulses once, 3 cycles after RST exit.
- lw with 2 waitrequest cycles, readdata 0xDEADBEEF: avm_address/avm_read held stable for 3 cycles; cpu_data_readdata=0xDEADBEEF at COMMIT; instruction total 6 cycles.
- sw to 0x00001004, data 0x12345678: exactly one cycle with avm_write=1, waitrequest=0, address 0x00001004, writedata 0x12345678; avm_read=0 in that cycle.
- Jump to 0 then cpu_active=0: state HALT, halted=1, no further avm_read.
- WAIT_LIMIT=4, waitrequest stuck high: bus_error=1 after 4 wait cycles, HALT, avm_read=0.
- Reset asserted mid-DRD with waitrequest high: next cycle avm_read=0; cpu_clk_enable=1 during the reset cycle; refetch starts after RST.

Source files
------------

// File: rtl/avalon_seq_pkg.sv
// Shared types and helpers for the Harvard-core Avalon sequencer.
// States, byte-enable constant and word-alignment of core addresses.
package avalon_seq_pkg;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    DRD    = 3'd3,
    DWR    = 3'd4,
    COMMIT = 3'd5,
    HALT   = 3'd6
  } seq_state_t;

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/avalon_wait_timer.sv
// Waitrequest watchdog: counts consecutive stalled cycles of one transfer
// and flags the cycle that reaches WAIT_LIMIT (WAIT_LIMIT=0 never expires).
module avalon_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturate so a disabled timeout cannot wrap back into a false match.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (WAIT_LIMIT != 0) && inc && (count_q == LAST_WAIT);

endmodule

// File: rtl/avalon_harvard_sequencer.sv
// Serialises the Harvard MIPS core's fetch and data ports onto one Avalon-MM
// master, stalling the core until each transfer completes.
// Optional perf counters: define AVALON_SEQ_PERF_COUNT_EN.
//
// state  | meaning
// RST    | one cycle after reset, core held
// FETCH  | instruction read at the PC
// EXEC   | core decodes instr_q, no bus traffic
// DRD    | data load on the bus
// DWR    | data store on the bus
// COMMIT | single core clock enable, architectural update
// HALT   | core finished or bus timed out, bus idle
module avalon_harvard_sequencer
  import avalon_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_active,
  input  logic [31:0]       cpu_instr_address,
  input  logic [31:0]       cpu_data_address,
  input  logic              cpu_data_read,
  input  logic              cpu_data_write,
  input  logic [31:0]       cpu_data_writedata,
  output logic [31:0]       cpu_instr_readdata,
  output logic [31:0]       cpu_data_readdata,
  output logic              cpu_clk_enable,
  output logic              cpu_pause,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              bus_error,
  output logic              halted
`ifdef AVALON_SEQ_PERF_COUNT_EN
  ,
  output logic [31:0]       perf_instr_count,
  output logic [31:0]       perf_stall_count
`endif
);

  seq_state_t  state_q;
  logic [31:0] instr_q;
  logic [31:0] data_q;
  logic        bus_error_q;

  logic        fetch_req;
  logic        wait_inc;
  logic        wait_expired;
  logic [31:0] bus_addr;

  assign fetch_req = (state_q == FETCH) && cpu_active;
  assign wait_inc  = (avm_read || avm_write) && avm_waitrequest;

  // Any cycle that is not a stalled transfer ends the current wait run.
  avalon_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!wait_inc),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST;
      instr_q     <= '0;
      data_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        RST: state_q <= FETCH;
        FETCH: begin
          if (!cpu_active) begin
            state_q <= HALT;
          end else if (wait_expired) begin
            bus_error_q <= 1'b1;
            state_q     <= HALT;
          end else if (!avm_waitrequest) begin
            instr_q <= avm_readdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cpu_data_read) begin
            state_q <= DRD;
            if (cpu_data_write) begin
              bus_error_q <= 1'b1;
            end
          end else if (cpu_data_write) begin
            state_q <= DWR;
          end else begin
            state_q <= COMMIT;
          end
        end
        DRD: begin
          if (wait_expired) begin
            bus_error_q <= 1'b1;
            state_q     <= HALT;
          end else if (!avm_waitrequest) begin
            data_q  <= avm_readdata;
            state_q <= COMMIT;
          end
        end
        DWR: begin
          if (wait_expired) begin
            bus_error_q <= 1'b1;
            state_q     <= HALT;
          end else if (!avm_waitrequest) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: state_q <= FETCH;
        HALT:   state_q <= HALT;
        default: state_q <= RST;
      endcase
    end
  end

  // Reset strobes the core clock so it resets alongside the sequencer.
  assign cpu_clk_enable = reset || (state_q == COMMIT);
  assign cpu_pause      = reset || (state_q != COMMIT);

  assign bus_addr       = (state_q == FETCH) ? cpu_instr_address : cpu_data_address;
  assign avm_address    = ADDR_W'(word_align(bus_addr));
  assign avm_read       = !reset && (fetch_req || (state_q == DRD));
  assign avm_write      = !reset && (state_q == DWR);
  assign avm_writedata  = cpu_data_writedata;
  assign avm_byteenable = BYTEENABLE_ALL;

  assign cpu_instr_readdata = instr_q;
  assign cpu_data_readdata  = data_q;
  assign bus_error          = bus_error_q;
  assign halted             = (state_q == HALT);

`ifdef AVALON_SEQ_PERF_COUNT_EN
  logic [31:0] perf_instr_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == COMMIT) begin
        perf_instr_q <= perf_instr_q + 32'd1;
      end
      if ((state_q == FETCH) || (state_q == EXEC) || (state_q == DRD) || (state_q == DWR)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_instr_count = perf_instr_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_avalon_harvard_sequencer.sv
// Directed bench for avalon_harvard_sequencer: per-cycle vector table plus
// hand sequences for reset mid-transfer, read/write conflict and timeout.
module tb_avalon_harvard_sequencer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] PC0     = 32'hBFC00000;
  localparam logic [31:0] I_ADDIU = 32'h24080005;
  localparam logic [31:0] I_LW    = 32'h8C090000;
  localparam logic [31:0] I_SW    = 32'hAD0A1004;
  localparam logic [31:0] I_J     = 32'h08000000;
  localparam logic [31:0] D_LW    = 32'hDEADBEEF;
  localparam logic [31:0] D_SW    = 32'h12345678;

  typedef struct {
    logic        rst;
    logic        act;
    logic [31:0] ia;
    logic [31:0] da;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        wreq;
    logic [31:0] rdat;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_ce;
    logic        e_pause;
    logic        e_halt;
    logic        e_err;
    logic [31:0] e_ir;
    logic [31:0] e_dr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        cpu_active;
  logic [31:0] cpu_instr_address;
  logic [31:0] cpu_data_address;
  logic        cpu_data_read;
  logic        cpu_data_write;
  logic [31:0] cpu_data_writedata;
  logic [31:0] cpu_instr_readdata;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        cpu_pause;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        bus_error;
  logic        halted;

  int checks = 0;
  int failures = 0;

  avalon_harvard_sequencer #(
    .ADDR_W     (32),
    .WAIT_LIMIT (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_active         (cpu_active),
    .cpu_instr_address  (cpu_instr_address),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_instr_readdata (cpu_instr_readdata),
    .cpu_data_readdata  (cpu_data_readdata),
    .cpu_clk_enable     (cpu_clk_enable),
    .cpu_pause          (cpu_pause),
    .avm_address        (avm_address),
    .avm_read           (avm_read),
    .avm_write          (avm_write),
    .avm_writedata      (avm_writedata),
    .avm_byteenable     (avm_byteenable),
    .avm_readdata       (avm_readdata),
    .avm_waitrequest    (avm_waitrequest),
    .bus_error          (bus_error),
    .halted             (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check 1 time unit later, then move on one cycle.
  task automatic apply(input vec_t v, input string tag);
    reset              = v.rst;
    cpu_active         = v.act;
    cpu_instr_address  = v.ia;
    cpu_data_address   = v.da;
    cpu_data_read      = v.rd;
    cpu_data_write     = v.wr;
    cpu_data_writedata = v.wd;
    avm_waitrequest    = v.wreq;
    avm_readdata       = v.rdat;
    #1;
    chk({tag, " rd/wr/ce/pause/halt/err"},
        {26'd0, avm_read, avm_write, cpu_clk_enable, cpu_pause, halted, bus_error},
        {26'd0, v.e_rd, v.e_wr, v.e_ce, v.e_pause, v.e_halt, v.e_err});
    if (v.e_rd || v.e_wr) chk({tag, " avm_address"}, avm_address, v.e_addr);
    if (v.e_wr) chk({tag, " avm_writedata"}, avm_writedata, v.wd);
    chk({tag, " instr_readdata"}, cpu_instr_readdata, v.e_ir);
    chk({tag, " data_readdata"}, cpu_data_readdata, v.e_dr);
    @(negedge clk);
  endtask

  vec_t tbl [21];

  initial begin
    //          rst act ia       da        rd wr wd    wreq rdat      e_rd e_wr e_addr     ce pause halt err ir       dr
    tbl[0]  = '{H, H, PC0,      32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    H, H, L, L, 32'h0,   32'h0};
    tbl[1]  = '{L, H, PC0,      32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, L, L, 32'h0,   32'h0};
    tbl[2]  = '{L, H, PC0,      32'h0,    L, L, 32'h0, L, I_ADDIU,  H, L, PC0,      L, H, L, L, 32'h0,   32'h0};
    tbl[3]  = '{L, H, PC0,      32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, L, L, I_ADDIU, 32'h0};
    tbl[4]  = '{L, H, PC0,      32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    H, L, L, L, I_ADDIU, 32'h0};
    tbl[5]  = '{L, H, PC0+4,    32'h0,    L, L, 32'h0, L, I_LW,     H, L, PC0+4,    L, H, L, L, I_ADDIU, 32'h0};
    tbl[6]  = '{L, H, PC0+4,    32'h2002, H, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, L, L, I_LW,    32'h0};
    tbl[7]  = '{L, H, PC0+4,    32'h2002, H, L, 32'h0, H, 32'h0,    H, L, 32'h2000, L, H, L, L, I_LW,    32'h0};
    tbl[8]  = '{L, H, PC0+4,    32'h2002, H, L, 32'h0, H, 32'h0,    H, L, 32'h2000, L, H, L, L, I_LW,    32'h0};
    tbl[9]  = '{L, H, PC0+4,    32'h2002, H, L, 32'h0, L, D_LW,     H, L, 32'h2000, L, H, L, L, I_LW,    32'h0};
    tbl[10] = '{L, H, PC0+4,    32'h2002, H, L, 32'h0, L, 32'h0,    L, L, 32'h0,    H, L, L, L, I_LW,    D_LW};
    tbl[11] = '{L, H, PC0+8,    32'h0,    L, L, 32'h0, L, I_SW,     H, L, PC0+8,    L, H, L, L, I_LW,    D_LW};
    tbl[12] = '{L, H, PC0+8,    32'h1004, L, H, D_SW,  L, 32'h0,    L, L, 32'h0,    L, H, L, L, I_SW,    D_LW};
    tbl[13] = '{L, H, PC0+8,    32'h1004, L, H, D_SW,  L, 32'h0,    L, H, 32'h1004, L, H, L, L, I_SW,    D_LW};
    tbl[14] = '{L, H, PC0+8,    32'h1004, L, H, D_SW,  L, 32'h0,    L, L, 32'h0,    H, L, L, L, I_SW,    D_LW};
    tbl[15] = '{L, H, PC0+12,   32'h0,    L, L, 32'h0, L, I_J,      H, L, PC0+12,   L, H, L, L, I_SW,    D_LW};
    tbl[16] = '{L, H, PC0+12,   32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, L, L, I_J,     D_LW};
    tbl[17] = '{L, H, PC0+12,   32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    H, L, L, L, I_J,     D_LW};
    tbl[18] = '{L, L, 32'h0,    32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, L, L, I_J,     D_LW};
    tbl[19] = '{L, L, 32'h0,    32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, H, L, I_J,     D_LW};
    tbl[20] = '{L, H, 32'h0,    32'h0,    L, L, 32'h0, L, 32'h0,    L, L, 32'h0,    L, H, H, L, I_J,     D_LW};

    reset = 1'b1; cpu_active = 1'b1; cpu_instr_address = PC0; cpu_data_address = '0;
    cpu_data_read = 1'b0; cpu_data_write = 1'b0; cpu_data_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    @(negedge clk);
    chk("byteenable", {28'd0, avm_byteenable}, 32'h0000000F);

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset out of HALT, then a read+write conflict, then reset mid-DRD.
    apply('{H, H, PC0, 32'h0,    L, L, 32'h0, L, 32'h0,   L, L, 32'h0,    H, H, H, L, I_J,     D_LW},  "rst_from_halt");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, L, 32'h0,   L, L, 32'h0,    L, H, L, L, 32'h0,   32'h0}, "rst_state_cleared");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, L, I_LW,    H, L, PC0,      L, H, L, L, 32'h0,   32'h0}, "conf_fetch");
    apply('{L, H, PC0, 32'h3000, H, H, 32'h0, L, 32'h0,   L, L, 32'h0,    L, H, L, L, I_LW,    32'h0}, "conf_exec");
    apply('{L, H, PC0, 32'h3000, H, H, 32'h0, H, 32'h0,   H, L, 32'h3000, L, H, L, H, I_LW,    32'h0}, "conf_drd_wait1");
    apply('{L, H, PC0, 32'h3000, H, H, 32'h0, H, 32'h0,   H, L, 32'h3000, L, H, L, H, I_LW,    32'h0}, "conf_drd_wait2");
    apply('{H, H, PC0, 32'h3000, H, H, 32'h0, H, 32'h0,   L, L, 32'h0,    H, H, L, H, I_LW,    32'h0}, "rst_mid_drd");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, H, 32'h0,   L, L, 32'h0,    L, H, L, L, 32'h0,   32'h0}, "rst_after_drd");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, L, I_ADDIU, H, L, PC0,      L, H, L, L, 32'h0,   32'h0}, "refetch");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, L, 32'h0,   L, L, 32'h0,    L, H, L, L, I_ADDIU, 32'h0}, "refetch_exec");
    apply('{L, H, PC0, 32'h0,    L, L, 32'h0, L, 32'h0,   L, L, 32'h0,    H, L, L, L, I_ADDIU, 32'h0}, "refetch_commit");

    // Waitrequest stuck high: four stalled cycles then timeout into HALT.
    for (int w = 1; w <= 4; w++) begin
      apply('{L, H, PC0+4, 32'h0, L, L, 32'h0, H, 32'h0, H, L, PC0+4, L, H, L, L, I_ADDIU, 32'h0},
            $sformatf("timeout_wait%0d", w));
    end
    apply('{L, H, PC0+4, 32'h0, L, L, 32'h0, H, 32'h0, L, L, 32'h0, L, H, H, H, I_ADDIU, 32'h0}, "timeout_halt");
    apply('{L, H, PC0+4, 32'h0, L, L, 32'h0, L, 32'h0, L, L, 32'h0, L, H, H, H, I_ADDIU, 32'h0}, "timeout_stays");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
